fmps_write_link: RTL
====================

# fmps_write_link

Transmit side of the FMPS cell link. On each fast-acquisition strobe, the block captures one FMPS status sample and emits a two-word AXI-stream packet on the Aurora TX stream. The packet is a header word followed by a data word, and is decoded by the FMPS read link at the far end. The block sits in the Aurora user-clock domain between the FMPS sampling logic and the Aurora TX FIFO, and also exports packet and overrun statistics.

## Interface
- `INDEX_WIDTH`, default 5: width of the FMPS index; legal range 1..5, because the index must fit in header bits 14:10.
- `auroraClk` in 1: sole clock; all logic is on its rising edge.
- `auroraReset` in 1: asynchronous, active-high reset.
- `FAstrobe` in 1: single-cycle request to send one packet.
- `fmpsEnabled` in 1: copied into header bit 15.
- `fmpsIndex` in INDEX_WIDTH: this FMPS's index, copied into header bits [10+:INDEX_WIDTH].
- `fmpsValid` in 1: 0 marks the sample invalid (data word bit 31 = 1).
- `fmpsForwardBad` in 1: 1 marks a bad forwarded packet (data word bit 30 = 1).
- `fmpsData` in 30: payload, placed in data word bits 29:0.
- `TVALID` out 1: AXI-stream valid.
- `TREADY` in 1: AXI-stream ready from the TX FIFO.
- `TLAST` out 1: high on the data word only.
- `TDATA` out 32: stream data.
- `busy` out 1: high while a packet is in flight (state ≠ S_IDLE).
- `packetCount` out 16: completed packets; wraps on overflow.
- `overrunCount` out 16: dropped strobes; saturates at 16'hFFFF.

## Operation
- **State machine:** S_IDLE, S_HEADER, S_DATA.
- **S_IDLE:**
  - On `FAstrobe`, capture `fmpsEnabled`, `fmpsIndex`, `fmpsValid`, `fmpsForwardBad` and `fmpsData` into holding registers.
  - Build both words and go to S_HEADER.
  - Later changes on the inputs do not affect the packet in flight.
- **Header word:**
  - [31:16] = 16'hB6CF.
  - [15] = enabled.
  - [10+:INDEX_WIDTH] = index.
  - All other bits = 0.
- **Data word:**
  - [31] = !valid.
  - [30] = forwardBad.
  - [29:0] = data.
- **S_HEADER:**
  - TVALID = 1, TLAST = 0, TDATA = header.
  - A beat is accepted when TVALID && TREADY; on acceptance go to S_DATA.
- **S_DATA:**
  - TVALID = 1, TLAST = 1, TDATA = data word.
  - On acceptance: increment `packetCount` (mod 2^16) and return to S_IDLE.
- **Handshake rules:**
  - While TVALID && !TREADY, TDATA and TLAST hold stable.
  - TVALID never deasserts before acceptance.
  - TVALID does not depend combinationally on TREADY.
- **Overrun:**
  - An `FAstrobe` in any state other than S_IDLE is dropped.
  - A drop includes the cycle in which the final beat is accepted.
  - Each drop increments `overrunCount`, saturating at 16'hFFFF.
  - The packet in flight is never altered or truncated.
- **Reset:** `auroraReset` asserted at any time, including mid-packet, forces:
  - state = S_IDLE;
  - TVALID = 0, TLAST = 0, TDATA = 0;
  - busy = 0;
  - packetCount = 0, overrunCount = 0;
  - holding registers = 0.
  
  No partial packet resumes after reset; the next strobe after reset release starts a fresh header.
- Outputs are registered; no combinational paths from inputs to outputs.

## Timing
- `FAstrobe` sampled high in S_IDLE at edge N: header is on TDATA with TVALID = 1 after edge N; `busy` rises at the same edge.
- With TREADY held high: header is accepted at edge N+1 and the data word at edge N+2.
  - TVALID falls after edge N+2, and `packetCount` updates at the same edge.
  - Minimum packet period is 3 cycles, so the earliest accepted next strobe is at edge N+3.
- Each cycle with TREADY low in S_HEADER or S_DATA adds one cycle of latency.
- `overrunCount` updates at the edge after the dropped strobe.
- Reset is asynchronous assert; release is synchronised to `auroraClk` by the surrounding reset logic.

## Test plan
- **Basic packet:**
  - Stimulus: INDEX_WIDTH = 5, `fmpsIndex` = 5'd19, `fmpsEnabled` = 1, `fmpsValid` = 1, `fmpsForwardBad` = 0, `fmpsData` = 30'h0ABCDEF, TREADY = 1, one strobe.
  - Required: beats 32'hB6CFCC00 (TLAST = 0), then 32'h00ABCDEF (TLAST = 1); `packetCount` = 1; TVALID high for exactly 2 cycles.
- **Invalid and bad-forward flags:**
  - Stimulus: `fmpsValid` = 0, `fmpsForwardBad` = 1, `fmpsData` = 0, `fmpsIndex` = 0, `fmpsEnabled` = 0.
  - Required: header 32'hB6CF0000, data 32'hC0000000.
- **Backpressure:**
  - Stimulus: TREADY low for 4 cycles during the header, then low for 3 cycles during the data word.
  - Required: TDATA and TLAST stable throughout; exactly 2 beats accepted; `packetCount` increments once, 9 cycles after the strobe.
- **Overrun:**
  - Stimulus: strobes at cycles 0, 1 and 2 (the cycle of the final beat), then at cycle 3, with TREADY = 1.
  - Required: `overrunCount` = 2; 2 complete packets; the first packet's payload is unchanged even though the inputs changed.
  - Separately, preload `overrunCount` to saturation via 65535 forced drops; one more drop leaves it at 16'hFFFF.
- **Reset mid-packet:**
  - Stimulus: assert `auroraReset` asynchronously while in S_DATA with TREADY = 0.
  - Required: TVALID, TLAST, `busy` and the counters are 0 immediately; a strobe after release emits a full fresh header and data pair.
- **Input isolation:**
  - Stimulus: change `fmpsData` and `fmpsIndex` every cycle while a packet is held by TREADY = 0.
  - Required: transmitted words match the values captured at the strobe.

Source files
------------

// File: rtl/fmps_write_link.sv
// FMPS cell link transmitter: captures one status sample per FA strobe
// and sends it as a header + data AXI-stream packet toward Aurora TX.
// Ports:
//   auroraClk/auroraReset                      clock, async active-high reset
//   FAstrobe                                   one-cycle packet request
//   fmpsEnabled/Index/Valid/ForwardBad/Data    sample fields
//   TVALID/TREADY/TLAST/TDATA                  AXI-stream master
//   busy                                       packet in flight
//   packetCount                                completed packets, wraps
//   overrunCount                               dropped strobes, saturates
module fmps_write_link #(
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   auroraClk,
    input  logic                   auroraReset,
    input  logic                   FAstrobe,
    input  logic                   fmpsEnabled,
    input  logic [INDEX_WIDTH-1:0] fmpsIndex,
    input  logic                   fmpsValid,
    input  logic                   fmpsForwardBad,
    input  logic [29:0]            fmpsData,
    output logic                   TVALID,
    input  logic                   TREADY,
    output logic                   TLAST,
    output logic [31:0]            TDATA,
    output logic                   busy,
    output logic [15:0]            packetCount,
    output logic [15:0]            overrunCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_DATA
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_tvalid;
    logic        r_tlast;
    logic [31:0] r_tdata;
    logic [31:0] r_dat_word;
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_ovr_cnt;

    logic        w_tvalid_nxt;
    logic        w_tlast_nxt;
    logic [31:0] w_tdata_nxt;
    logic [31:0] w_dat_nxt;
    logic        w_pkt_inc;
    logic        w_accept;
    logic        w_drop;
    logic [31:0] w_hdr_word;
    logic [31:0] w_dat_word;

    // Words are formed from the live inputs only at capture time.
    always_comb begin
        w_hdr_word                     = '0;
        w_hdr_word[31:16]              = 16'hB6CF;
        w_hdr_word[15]                 = fmpsEnabled;
        w_hdr_word[10 +: INDEX_WIDTH]  = fmpsIndex;
        w_dat_word                     = {~fmpsValid, fmpsForwardBad, fmpsData};
    end

    assign w_accept = r_tvalid & TREADY;
    // The final-beat cycle is still non-idle, so a strobe there drops.
    assign w_drop   = FAstrobe & (r_state != S_IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_tvalid_nxt = r_tvalid;
        w_tlast_nxt  = r_tlast;
        w_tdata_nxt  = r_tdata;
        w_dat_nxt    = r_dat_word;
        w_pkt_inc    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (FAstrobe) begin
                    w_state_nxt  = S_HEADER;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = 1'b0;
                    w_tdata_nxt  = w_hdr_word;
                    w_dat_nxt    = w_dat_word;
                end
            end
            S_HEADER: begin
                if (w_accept) begin
                    w_state_nxt = S_DATA;
                    w_tlast_nxt = 1'b1;
                    w_tdata_nxt = r_dat_word;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_state_nxt  = S_IDLE;
                    w_tvalid_nxt = 1'b0;
                    w_tlast_nxt  = 1'b0;
                    w_tdata_nxt  = '0;
                    w_pkt_inc    = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_tvalid_nxt = 1'b0;
                w_tlast_nxt  = 1'b0;
                w_tdata_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge auroraClk or posedge auroraReset) begin
        if (auroraReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge auroraClk or posedge auroraReset) begin
        if (auroraReset) begin
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdata    <= '0;
            r_dat_word <= '0;
            r_pkt_cnt  <= '0;
            r_ovr_cnt  <= '0;
        end else begin
            r_tvalid   <= w_tvalid_nxt;
            r_tlast    <= w_tlast_nxt;
            r_tdata    <= w_tdata_nxt;
            r_dat_word <= w_dat_nxt;
            if (w_pkt_inc) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (w_drop && (r_ovr_cnt != 16'hFFFF)) begin
                r_ovr_cnt <= r_ovr_cnt + 16'd1;
            end
        end
    end

    assign TVALID       = r_tvalid;
    assign TLAST        = r_tlast;
    assign TDATA        = r_tdata;
    assign busy         = (r_state != S_IDLE);
    assign packetCount  = r_pkt_cnt;
    assign overrunCount = r_ovr_cnt;

endmodule
